conv_line_scheduler: RTL and testbench
======================================

// Module: conv_line_scheduler
// PURPOSE
//  Sequences conv1 layer processing through conv_MAC, which is a 5x5 multiply-accumulate block with 3 output channels.
//  Gates window-buffer -> MAC handshake; counts convolutions per line and lines per frame.
//  At each line end: drains in-flight MAC results, then drives a fixed-length weight_shift burst.
//  Sits between window buffer, conv_MAC and pooling stage; top-level FSM raises start/observes frame_done.
// PARAMETERS
//  CONV_PER_LINE  24  output columns per line (windows accepted per line)
//  LINES          24  output rows per frame
//  WSHIFT_CYCLES  4   cycles weight_shift held high between lines
//  MAX_PENDING    2   max windows issued to MAC without a returned result
// PORTS
//  clk            in   1  clock, rising edge
//  rst_n          in   1  asynchronous active-low reset
//  start          in   1  pulse; begins a frame (ignored unless IDLE)
//  valid_win      in   1  window buffer has window_data valid
//  ready_win      out  1  to window buffer: window accepted this cycle if valid_win
//  valid_win_MAC  out  1  to conv_MAC valid_win_MAC
//  ready_MAC      in   1  from conv_MAC
//  mac_done       in   1  MAC result consumed (conv_MAC valid_out && ready_pool)
//  weight_shift   out  1  to conv_MAC: shift weight/line context
//  conv_col       out  5  column index of next window to accept (0..CONV_PER_LINE-1)
//  conv_row       out  5  current line index (0..LINES-1)
//  line_done      out  1  1-cycle pulse when a line's shift burst completes
//  busy           out  1  high in any state except IDLE
//  frame_done     out  1  1-cycle pulse in DONE
// BEHAVIOUR
//  Reset: state=IDLE, all counters 0, all outputs 0. Reset mid-frame aborts instantly; no pulses emitted.
//  States: IDLE, RUN, DRAIN, SHIFT, DONE (state register only; outputs decoded).
//  IDLE: start=1 -> RUN; conv_col/conv_row/pending/shift_cnt cleared on same edge.
//  RUN: gate = (pending < MAX_PENDING).
//   valid_win_MAC = valid_win & gate.
//   ready_win = ready_MAC & gate. These are combinational, 0 latency.
//   accept = valid_win & ready_win. On accept, conv_col++.
//   accept with conv_col==CONV_PER_LINE-1: conv_col->0, go DRAIN.
//  pending: +1 on accept, -1 on mac_done; both in the same cycle -> unchanged.
//   mac_done with pending==0 is ignored (saturate at 0). Counter is updated in all non-IDLE states.
//  DRAIN: ready_win=0, valid_win_MAC=0.
//   Leave when next pending==0 (counts a same-cycle mac_done).
//   Go to SHIFT if conv_row<LINES-1, else DONE.
//  SHIFT: weight_shift=1 for exactly WSHIFT_CYCLES cycles (shift_cnt 0..WSHIFT_CYCLES-1).
//   Last cycle: conv_row++, line_done=1, go RUN.
//  DONE: frame_done=1 for one cycle, busy=1 -> IDLE. No weight_shift after the last line.
//  start while busy: ignored. valid_win in IDLE/DRAIN/SHIFT/DONE: never accepted.
//  conv_col/conv_row are registered and valid in all states; they hold their last values in IDLE.
// STRUCTURE
//  conv_sched_pkg: state enum (IDLE..DONE); localparam widths $clog2 of CONV_PER_LINE, LINES, MAX_PENDING+1, WSHIFT_CYCLES.
//  One sub-module, conv_sched_wrap_cnt: enable/clear counter with wrap flag at MAX.
//  Three instances: column counter, row counter, shift counter. pending counter stays inline.
// TESTING
//  1. Full frame; valid_win=1, ready_MAC=1, mac_done 6 cycles after each accept
//     -> 576 accepts; 23 bursts of 4 weight_shift cycles; 23 line_done; 1 frame_done; pending==0 at end.
//  2. ready_MAC=0 for 10 cycles mid-line (col=7)
//     -> ready_win=0, conv_col stays 7, no accept; resumes at col 7.
//  3. MAX_PENDING=2, mac_done withheld
//     -> exactly 2 accepts, then ready_win=0. One mac_done -> next accept.
//     Same-cycle accept+mac_done keeps pending=2.
//  4. Line end with 2 pending; mac_done returns 3 cycles later
//     -> DRAIN for 3 cycles, then weight_shift high 4 cycles, conv_row 0->1, conv_col=0.
//  5. start pulsed during RUN at row 5 -> ignored; counters undisturbed; single frame_done.
//  6. rst_n low during SHIFT at row 10 -> immediate IDLE, all outputs 0, no line_done.
//     A new start restarts at row 0, col 0.

Source files
------------

// File: rtl/conv_sched_pkg.sv
// rtl/conv_sched_pkg.sv - shared constants, widths and state type for the conv line scheduler
package conv_sched_pkg;

    localparam int CONV_PER_LINE = 24;
    localparam int LINES         = 24;
    localparam int WSHIFT_CYCLES = 4;
    localparam int MAX_PENDING   = 2;

    localparam int COL_W  = $clog2(CONV_PER_LINE);
    localparam int ROW_W  = $clog2(LINES);
    localparam int PEND_W = $clog2(MAX_PENDING + 1);
    localparam int SH_W   = $clog2(WSHIFT_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_SHIFT,
        ST_DONE
    } state_e;

endpackage

// File: rtl/conv_sched_wrap_cnt.sv
// rtl/conv_sched_wrap_cnt.sv - enable/clear counter that wraps to zero after MAX
module conv_sched_wrap_cnt #(
    parameter int WIDTH = 5,
    parameter int MAX   = 23
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             wrap_o
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == MAX_V) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign wrap_o = (cnt_q == MAX_V);

endmodule

// File: rtl/conv_line_scheduler.sv
// rtl/conv_line_scheduler.sv - gates window->MAC handshake, drains and weight-shifts at each line end
module conv_line_scheduler
    import conv_sched_pkg::*;
#(
    parameter int CONV_PER_LINE_P = CONV_PER_LINE,
    parameter int LINES_P         = LINES,
    parameter int WSHIFT_CYCLES_P = WSHIFT_CYCLES,
    parameter int MAX_PENDING_P   = MAX_PENDING
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             valid_win,
    output logic             ready_win,
    output logic             valid_win_MAC,
    input  logic             ready_MAC,
    input  logic             mac_done,
    output logic             weight_shift,
    output logic [COL_W-1:0] conv_col,
    output logic [ROW_W-1:0] conv_row,
    output logic             line_done,
    output logic             busy,
    output logic             frame_done
);

    state_e            state_q;
    logic [PEND_W-1:0] pend_q;
    logic [PEND_W-1:0] pend_d;
    logic [SH_W-1:0]   sh_cnt;

    logic frame_start;
    logic gate;
    logic accept;
    logic col_last;
    logic row_last;
    logic sh_last;
    logic in_run;
    logic in_shift;

    assign in_run      = (state_q == ST_RUN);
    assign in_shift    = (state_q == ST_SHIFT);
    assign frame_start = (state_q == ST_IDLE) && start;

    assign gate          = (pend_q < PEND_W'(MAX_PENDING_P));
    assign ready_win     = in_run && ready_MAC && gate;
    assign valid_win_MAC = in_run && valid_win && gate;
    assign accept        = valid_win && ready_win;

    // A result returned in the same cycle as a new issue cancels out; a stray
    // result with nothing outstanding is dropped rather than underflowing.
    always_comb begin
        pend_d = pend_q;
        if (frame_start) begin
            pend_d = '0;
        end else if (state_q != ST_IDLE) begin
            if (accept && !mac_done) begin
                pend_d = pend_q + 1'b1;
            end else if (!accept && mac_done && (pend_q != '0)) begin
                pend_d = pend_q - 1'b1;
            end
        end
    end

    conv_sched_wrap_cnt #(.WIDTH(COL_W), .MAX(CONV_PER_LINE_P - 1)) u_col_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (frame_start),
        .en_i   (accept),
        .cnt_o  (conv_col),
        .wrap_o (col_last)
    );

    conv_sched_wrap_cnt #(.WIDTH(ROW_W), .MAX(LINES_P - 1)) u_row_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (frame_start),
        .en_i   (in_shift && sh_last),
        .cnt_o  (conv_row),
        .wrap_o (row_last)
    );

    conv_sched_wrap_cnt #(.WIDTH(SH_W), .MAX(WSHIFT_CYCLES_P - 1)) u_shift_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (frame_start),
        .en_i   (in_shift),
        .cnt_o  (sh_cnt),
        .wrap_o (sh_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
        end else begin
            pend_q <= pend_d;
            case (state_q)
                ST_IDLE:  if (start) state_q <= ST_RUN;
                ST_RUN:   if (accept && col_last) state_q <= ST_DRAIN;
                // The last line skips the weight shift and ends the frame.
                ST_DRAIN: if (pend_d == '0) state_q <= row_last ? ST_DONE : ST_SHIFT;
                ST_SHIFT: if (sh_last) state_q <= ST_RUN;
                ST_DONE:  state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    assign weight_shift = in_shift;
    assign line_done    = in_shift && sh_last;
    assign busy         = (state_q != ST_IDLE);
    assign frame_done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_conv_line_scheduler.sv
// tb/tb_conv_line_scheduler.sv - directed bench with a per-cycle behavioural model of the scheduler
module tb_conv_line_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       valid_win;
    logic       ready_win;
    logic       valid_win_MAC;
    logic       ready_MAC;
    logic       mac_done = 1'b0;
    logic       weight_shift;
    logic [4:0] conv_col;
    logic [4:0] conv_row;
    logic       line_done;
    logic       busy;
    logic       frame_done;

    conv_line_scheduler dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .valid_win     (valid_win),
        .ready_win     (ready_win),
        .valid_win_MAC (valid_win_MAC),
        .ready_MAC     (ready_MAC),
        .mac_done      (mac_done),
        .weight_shift  (weight_shift),
        .conv_col      (conv_col),
        .conv_row      (conv_row),
        .line_done     (line_done),
        .busy          (busy),
        .frame_done    (frame_done)
    );

    always #5 clk = ~clk;

    localparam int NCOL = 24;
    localparam int NROW = 24;
    localparam int NSH  = 4;
    localparam int NPEND = 2;
    localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2, P_SHIFT = 3, P_DONE = 4;

    int total = 0;
    int bad   = 0;

    int cnt_acc = 0, cnt_ws = 0, cnt_ld = 0, cnt_fd = 0;
    int cyc = 0;
    bit mac_auto = 1'b1;
    bit mac_force = 1'b0;
    int mac_q[$];

    int m_ph = P_IDLE, m_col = 0, m_row = 0, m_pend = 0, m_sh = 0;
    int e_rw, e_vm, e_ws, e_ld, e_fd, e_bz;
    bit m_acc;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int pnext(input int p, input bit a, input bit d);
        if (a && d) return p;
        if (a) return p + 1;
        if (d && p > 0) return p - 1;
        return p;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            m_ph = P_IDLE; m_col = 0; m_row = 0; m_pend = 0; m_sh = 0;
        end
        e_rw = int'(m_ph == P_RUN && ready_MAC && m_pend < NPEND);
        e_vm = int'(m_ph == P_RUN && valid_win && m_pend < NPEND);
        e_ws = int'(m_ph == P_SHIFT);
        e_ld = int'(m_ph == P_SHIFT && m_sh == NSH - 1);
        e_fd = int'(m_ph == P_DONE);
        e_bz = int'(m_ph != P_IDLE);
        chk("ready_win", int'(ready_win), e_rw);
        chk("valid_win_MAC", int'(valid_win_MAC), e_vm);
        chk("weight_shift", int'(weight_shift), e_ws);
        chk("line_done", int'(line_done), e_ld);
        chk("frame_done", int'(frame_done), e_fd);
        chk("busy", int'(busy), e_bz);
        chk("conv_col", int'(conv_col), m_col);
        chk("conv_row", int'(conv_row), m_row);

        if (valid_win && ready_win) begin
            cnt_acc++;
            if (mac_auto) mac_q.push_back(cyc + 6);
        end
        if (weight_shift) cnt_ws++;
        if (line_done) cnt_ld++;
        if (frame_done) cnt_fd++;

        if (rst_n) begin
            m_acc = (e_rw != 0) && valid_win;
            case (m_ph)
                P_IDLE: if (start) begin
                    m_ph = P_RUN; m_col = 0; m_row = 0; m_pend = 0; m_sh = 0;
                end
                P_RUN: begin
                    m_pend = pnext(m_pend, m_acc, mac_done);
                    if (m_acc) begin
                        if (m_col == NCOL - 1) begin
                            m_col = 0; m_ph = P_DRAIN;
                        end else begin
                            m_col++;
                        end
                    end
                end
                P_DRAIN: begin
                    m_pend = pnext(m_pend, 1'b0, mac_done);
                    if (m_pend == 0) m_ph = (m_row < NROW - 1) ? P_SHIFT : P_DONE;
                end
                P_SHIFT: begin
                    m_pend = pnext(m_pend, 1'b0, mac_done);
                    if (m_sh == NSH - 1) begin
                        m_sh = 0; m_row++; m_ph = P_RUN;
                    end else begin
                        m_sh++;
                    end
                end
                default: begin
                    m_pend = pnext(m_pend, 1'b0, mac_done);
                    m_ph = P_IDLE;
                end
            endcase
        end
    end

    // conv_MAC stand-in: returns each result a fixed delay after issue, or follows mac_force
    always @(posedge clk) begin
        cyc = cyc + 1;
        #2;
        if (mac_auto) begin
            if (mac_q.size() > 0 && mac_q[0] <= cyc) begin
                mac_done = 1'b1;
                void'(mac_q.pop_front());
            end else begin
                mac_done = 1'b0;
            end
        end else begin
            mac_done = mac_force;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_frame(input string name, input int bound);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < bound; i++) begin
            step();
            if (frame_done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk(name, 0, 1);
        step();
        step();
    endtask

    int a0, l0, f0, w0;
    bit found;

    initial begin
        rst_n = 1'b0; start = 1'b0; valid_win = 1'b0; ready_MAC = 1'b0;
        repeat (3) step();
        chk("rst_busy", int'(busy), 0);
        chk("rst_col", int'(conv_col), 0);
        chk("rst_row", int'(conv_row), 0);
        rst_n = 1'b1;
        step();

        // full frame, results return 6 cycles after issue
        a0 = cnt_acc; l0 = cnt_ld; f0 = cnt_fd; w0 = cnt_ws;
        valid_win = 1'b1; ready_MAC = 1'b1;
        pulse_start();
        wait_frame("t1_frame_timeout", 20000);
        chk("t1_accepts", cnt_acc - a0, 576);
        chk("t1_wshift_cycles", cnt_ws - w0, 92);
        chk("t1_line_done", cnt_ld - l0, 23);
        chk("t1_frame_done", cnt_fd - f0, 1);
        chk("t1_idle", int'(busy), 0);
        chk("t1_results_outstanding", mac_q.size(), 0);

        // ready_MAC stall at col 7, then a stray start at row 5
        a0 = cnt_acc; l0 = cnt_ld; f0 = cnt_fd;
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (conv_col == 5'd7) begin found = 1'b1; break; end
            step();
        end
        chk("t2_reach_col7", int'(found), 1);
        ready_MAC = 1'b0;
        w0 = cnt_acc;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t2_stall_col", int'(conv_col), 7);
            chk("t2_stall_ready", int'(ready_win), 0);
        end
        chk("t2_stall_accepts", cnt_acc - w0, 0);
        ready_MAC = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            if (conv_col != 5'd7) break;
        end
        chk("t2_resume_col", int'(conv_col), 8);
        found = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            step();
            if (conv_row == 5'd5) begin found = 1'b1; break; end
        end
        chk("t5_reach_row5", int'(found), 1);
        pulse_start();
        chk("t5_row_kept", int'(conv_row), 5);
        chk("t5_busy", int'(busy), 1);
        wait_frame("t5_frame_timeout", 20000);
        chk("t5_accepts", cnt_acc - a0, 576);
        chk("t5_line_done", cnt_ld - l0, 23);
        chk("t5_frame_done", cnt_fd - f0, 1);

        // pending limit with results withheld
        mac_auto = 1'b0; mac_force = 1'b0;
        a0 = cnt_acc;
        pulse_start();
        repeat (5) step();
        chk("t3_two_accepts", cnt_acc - a0, 2);
        chk("t3_blocked", int'(ready_win), 0);
        chk("t3_col", int'(conv_col), 2);
        mac_force = 1'b1;
        step();
        step();
        mac_force = 1'b0;
        step();
        step();
        chk("t3_accepts_after_done", cnt_acc - a0, 4);
        chk("t3_col4", int'(conv_col), 4);
        chk("t3_blocked_again", int'(ready_win), 0);

        // line end with two results outstanding, returned late
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (conv_col == 5'd23) begin mac_force = 1'b0; found = 1'b1; break; end
            mac_force = 1'b1;
        end
        chk("t4_reach_col23", int'(found), 1);
        step();
        chk("t4_d1_ws", int'(weight_shift), 0);
        chk("t4_d1_busy", int'(busy), 1);
        chk("t4_d1_ready", int'(ready_win), 0);
        chk("t4_d1_col", int'(conv_col), 0);
        step();
        chk("t4_d2_ws", int'(weight_shift), 0);
        mac_force = 1'b1;
        step();
        chk("t4_d3_ws", int'(weight_shift), 0);
        step();
        mac_force = 1'b0;
        for (int s = 1; s <= 4; s++) begin
            chk("t4_shift_ws", int'(weight_shift), 1);
            chk("t4_shift_line_done", int'(line_done), int'(s == 4));
            chk("t4_shift_row", int'(conv_row), 0);
            step();
        end
        chk("t4_after_ws", int'(weight_shift), 0);
        chk("t4_after_row", int'(conv_row), 1);
        chk("t4_after_col", int'(conv_col), 0);

        // reset during the shift that follows row 10
        mac_force = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            step();
            if (conv_row == 5'd10 && weight_shift) begin found = 1'b1; break; end
        end
        chk("t6_reach_shift_row10", int'(found), 1);
        l0 = cnt_ld;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_ws", int'(weight_shift), 0);
        chk("t6_rst_line_done", int'(line_done), 0);
        chk("t6_rst_row", int'(conv_row), 0);
        chk("t6_rst_col", int'(conv_col), 0);
        chk("t6_rst_ready", int'(ready_win), 0);
        repeat (3) step();
        chk("t6_no_line_done", cnt_ld - l0, 0);
        rst_n = 1'b1;
        mac_force = 1'b0;
        step();
        pulse_start();
        chk("t6_restart_row", int'(conv_row), 0);
        chk("t6_restart_col", int'(conv_col), 0);
        chk("t6_restart_busy", int'(busy), 1);
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
